// File: rtl/sd_arb_pkg.sv
// Shared types for the SD block-channel arbiter: FSM state encoding and
// command direction codes.
package sd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_XFER,
    ST_DONE
  } sd_arb_state_t;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

endpackage

// File: rtl/sd_blk_arbiter_req_latch.sv
// Per-requester command capture: a read/write pulse latches direction and LBA
// while nothing is pending for that requester; cleared when the arbiter grants.
module sd_req_latch
  import sd_arb_pkg::*;
#(
  parameter int LBA_W = 32
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             req_rd,
  input  logic             req_wr,
  input  logic [LBA_W-1:0] req_lba,
  input  logic             clr,
  output logic             pending,
  output logic             dir,
  output logic [LBA_W-1:0] lba
);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pending <= 1'b0;
      dir     <= DIR_RD;
      lba     <= '0;
    end else if (clr) begin
      pending <= 1'b0;
    end else if (!pending && (req_rd || req_wr)) begin
      // read wins when both strobes arrive together
      pending <= 1'b1;
      dir     <= req_rd ? DIR_RD : DIR_WR;
      lba     <= req_lba;
    end
  end

endmodule

// File: rtl/sd_blk_arbiter.sv
// Round-robin sharing of the HPS SD block channel between two requesters.
// Optional timeout on ISSUE+XFER enabled with `define SD_TIMEOUT_EN.
module sd_blk_arbiter
  import sd_arb_pkg::*;
#(
  parameter int          LBA_W     = 32,
  parameter logic [23:0] TO_CYCLES = 24'hFFFFFF
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [1:0]       req_rd,
  input  logic [1:0]       req_wr,
  input  logic [LBA_W-1:0] req_lba0,
  input  logic [LBA_W-1:0] req_lba1,
  output logic [1:0]       req_done,
  output logic [1:0]       req_err,
  output logic [1:0]       req_busy,
  output logic             owner,
  output logic [LBA_W-1:0] sd_lba,
  output logic             sd_rd,
  output logic             sd_wr,
  input  logic             sd_ack,
  input  logic             sd_buff_wr,
  output logic [7:0]       sd_buff_din,
  input  logic [7:0]       buf_q0,
  input  logic [7:0]       buf_q1,
  output logic [1:0]       buf_wr
);

  sd_arb_state_t    state, state_nxt;
  logic [1:0]       pending, dir, grant_clr;
  logic [LBA_W-1:0] lba0_q, lba1_q;
  logic             last_owner, old_ack, grant, winner, to_hit;

  sd_req_latch #(.LBA_W(LBA_W)) u_latch0 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .req_rd  (req_rd[0]),
    .req_wr  (req_wr[0]),
    .req_lba (req_lba0),
    .clr     (grant_clr[0]),
    .pending (pending[0]),
    .dir     (dir[0]),
    .lba     (lba0_q)
  );

  sd_req_latch #(.LBA_W(LBA_W)) u_latch1 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .req_rd  (req_rd[1]),
    .req_wr  (req_wr[1]),
    .req_lba (req_lba1),
    .clr     (grant_clr[1]),
    .pending (pending[1]),
    .dir     (dir[1]),
    .lba     (lba1_q)
  );

`ifdef SD_TIMEOUT_EN
  logic [23:0] to_cnt;

  always_ff @(posedge clk_sys) begin
    if (reset || grant)
      to_cnt <= '0;
    else if (state == ST_ISSUE || state == ST_XFER)
      to_cnt <= to_cnt + 24'd1;
  end

  assign to_hit = (state == ST_ISSUE || state == ST_XFER) &&
                  (to_cnt == TO_CYCLES - 24'd1);
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    winner = ~last_owner;
    if (pending == 2'b01)
      winner = 1'b0;
    else if (pending == 2'b10)
      winner = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    unique case (state)
      ST_IDLE: if (|pending) begin
        grant     = 1'b1;
        state_nxt = ST_ISSUE;
      end
      ST_ISSUE: if (to_hit) state_nxt = ST_IDLE;
                else if (sd_ack) state_nxt = ST_XFER;
      ST_XFER:  if (to_hit) state_nxt = ST_IDLE;
                else if (old_ack && !sd_ack) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign grant_clr = {grant && winner, grant && !winner};

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      sd_lba     <= '0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      old_ack    <= 1'b0;
      req_done   <= '0;
      req_err    <= '0;
    end else begin
      state    <= state_nxt;
      old_ack  <= sd_ack;
      req_done <= '0;
      req_err  <= '0;
      if (grant) begin
        owner      <= winner;
        last_owner <= winner;
        sd_lba     <= winner ? lba1_q : lba0_q;
        sd_rd      <= (dir[winner] == DIR_RD);
        sd_wr      <= (dir[winner] == DIR_WR);
      end
      // command strobes end on the HPS ack or on a timeout abort
      if (state == ST_ISSUE && state_nxt != ST_ISSUE) begin
        sd_rd <= 1'b0;
        sd_wr <= 1'b0;
      end
      if (state == ST_DONE)
        req_done[owner] <= 1'b1;
      if (to_hit)
        req_err[owner] <= 1'b1;
    end
  end

  assign req_busy[0] = pending[0] | ((state != ST_IDLE) && !owner);
  assign req_busy[1] = pending[1] | ((state != ST_IDLE) && owner);

  assign sd_buff_din = owner ? buf_q1 : buf_q0;

  always_comb begin
    buf_wr = '0;
    if (state == ST_XFER)
      buf_wr[owner] = sd_buff_wr;
  end

endmodule

// File: tb/tb_sd_blk_arbiter.sv
// Self-checking bench for sd_blk_arbiter: vector table of arbitration cases,
// hand sequences for latency, buffer steering, ignored pulses, reset and timeout.
module tb_sd_blk_arbiter;

`ifdef SD_TIMEOUT_EN
  localparam logic [23:0] TB_TO = 24'd100;
`else
  localparam logic [23:0] TB_TO = 24'hFFFFFF;
`endif

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [1:0]  req_rd, req_wr;
  logic [31:0] req_lba0, req_lba1;
  logic [1:0]  req_done, req_err, req_busy, buf_wr;
  logic        owner, sd_rd, sd_wr, sd_ack, sd_buff_wr;
  logic [31:0] sd_lba;
  logic [7:0]  sd_buff_din, buf_q0, buf_q1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] sb_q[$];   // {req_err, req_done} expected in order

  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [31:0] lba0;
    logic [31:0] lba1;
    int unsigned n;
    logic        own_a;
    logic [31:0] lba_a;
    logic        wr_a;
    logic        own_b;
    logic [31:0] lba_b;
    logic        wr_b;
  } vec_t;

  vec_t vecs[7];

  sd_blk_arbiter #(.LBA_W(32), .TO_CYCLES(TB_TO)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .req_rd      (req_rd),
    .req_wr      (req_wr),
    .req_lba0    (req_lba0),
    .req_lba1    (req_lba1),
    .req_done    (req_done),
    .req_err     (req_err),
    .req_busy    (req_busy),
    .owner       (owner),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .sd_buff_wr  (sd_buff_wr),
    .sd_buff_din (sd_buff_din),
    .buf_q0      (buf_q0),
    .buf_q1      (buf_q1),
    .buf_wr      (buf_wr)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Scoreboard: every done/err pulse must match the next expected entry.
  always @(negedge clk_sys) begin
    if (!reset && (req_done != 2'b00 || req_err != 2'b00)) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got done=%b err=%b expected none", req_done, req_err);
      end else begin
        check("sb_pulse", {req_err, req_done}, sb_q.pop_front());
      end
    end
  end

  task automatic clear_inputs();
    req_rd = '0; req_wr = '0; req_lba0 = '0; req_lba1 = '0;
    sd_ack = 1'b0; sd_buff_wr = 1'b0; buf_q0 = '0; buf_q1 = '0;
  endtask

  task automatic do_reset();
    @(posedge clk_sys); #1;
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk_sys);
    #1 reset = 1'b0;
  endtask

  task automatic wait_cmd(output logic ok);
    int unsigned cnt;
    cnt = 0;
    @(negedge clk_sys);
    while (!(sd_rd || sd_wr) && cnt < 50) begin
      @(negedge clk_sys);
      cnt++;
    end
    ok = sd_rd || sd_wr;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL cmd_wait: got no sd_rd/sd_wr expected one within 50 cycles");
    end
  endtask

  // Plays the HPS side for one granted command and checks the full handshake.
  task automatic serve(input logic own, input logic [31:0] elba, input logic ewr,
                       input int unsigned nbytes);
    logic ok;
    int unsigned hold;
    logic [1:0] mask;
    mask = own ? 2'b10 : 2'b01;
    wait_cmd(ok);
    if (!ok) return;
    check("owner", owner, own);
    check("sd_lba", sd_lba, elba);
    check("sd_rdwr", {sd_rd, sd_wr}, ewr ? 2'b01 : 2'b10);
    check("busy_own", req_busy[own], 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_sys); #1 sd_buff_wr = 1'b1;
      @(negedge clk_sys);
      check("buf_wr_issue", buf_wr, 2'b00);
      check("rdwr_hold", {sd_rd, sd_wr}, ewr ? 2'b01 : 2'b10);
    end
    @(posedge clk_sys); #1 sd_buff_wr = 1'b0; sd_ack = 1'b1;
    @(posedge clk_sys); #1;
    hold = (nbytes > 3) ? nbytes : 3;
    for (int unsigned i = 0; i < hold; i++) begin
      sd_buff_wr = (i < nbytes);
      buf_q0 = 8'($urandom_range(255));
      buf_q1 = 8'($urandom_range(255));
      @(negedge clk_sys);
      check("buf_wr_xfer", buf_wr, (i < nbytes) ? mask : 2'b00);
      check("buff_din", sd_buff_din, own ? buf_q1 : buf_q0);
      if (i == 0) check("rdwr_drop", {sd_rd, sd_wr}, 2'b00);
      @(posedge clk_sys); #1;
    end
    sd_buff_wr = 1'b0;
    sd_ack = 1'b0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("done_early", req_done, 2'b00);
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("done_lat", req_done, mask);
    @(negedge clk_sys);
    check("done_1cyc", req_done, 2'b00);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b11, 2'b00, 32'hA0, 32'hA1, 2, 1'b1, 32'hA1, 1'b0, 1'b0, 32'hA0, 1'b0};
    vecs[1] = '{2'b10, 2'b00, 32'hB0, 32'hB1, 1, 1'b1, 32'hB1, 1'b0, 1'b0, 32'h0,  1'b0};
    vecs[2] = '{2'b00, 2'b11, 32'hC0, 32'hC1, 2, 1'b0, 32'hC0, 1'b1, 1'b1, 32'hC1, 1'b1};
    vecs[3] = '{2'b01, 2'b10, 32'hD0, 32'hD1, 2, 1'b0, 32'hD0, 1'b0, 1'b1, 32'hD1, 1'b1};
    vecs[4] = '{2'b11, 2'b11, 32'hE0, 32'hE1, 2, 1'b0, 32'hE0, 1'b0, 1'b1, 32'hE1, 1'b0};
    vecs[5] = '{2'b01, 2'b00, 32'hF0, 32'hF1, 1, 1'b0, 32'hF0, 1'b0, 1'b0, 32'h0,  1'b0};
    vecs[6] = '{2'b00, 2'b10, 32'h70, 32'h71, 1, 1'b1, 32'h71, 1'b1, 1'b0, 32'h0,  1'b0};

    reset = 1'b1;
    clear_inputs();
    sd_buff_wr = 1'b1;
    sd_ack = 1'b1;
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_done", req_done, 2'b00);
    check("rst_err", req_err, 2'b00);
    check("rst_busy", req_busy, 2'b00);
    check("rst_owner", owner, 1'b0);
    check("rst_lba", sd_lba, 32'h0);
    check("rst_rdwr", {sd_rd, sd_wr}, 2'b00);
    check("rst_buf_wr", buf_wr, 2'b00);
    @(posedge clk_sys); #1;
    reset = 1'b0;
    clear_inputs();

    // single read from requester 0: pulse -> sd_rd two cycles later
    @(posedge clk_sys); #1;
    req_rd = 2'b01; req_lba0 = 32'h10;
    sb_q.push_back(4'b0001);
    @(posedge clk_sys); #1;
    req_rd = 2'b00;
    @(negedge clk_sys);
    check("lat_busy", req_busy, 2'b01);
    check("lat_rd_early", sd_rd, 1'b0);
    @(negedge clk_sys);
    check("lat_rd", sd_rd, 1'b1);
    serve(1'b0, 32'h10, 1'b0, 0);

    // simultaneous writes after reset: req 0 first, then req 1 with buffer traffic
    do_reset();
    @(posedge clk_sys); #1;
    req_wr = 2'b11; req_lba0 = 32'h20; req_lba1 = 32'h21;
    sb_q.push_back(4'b0001);
    sb_q.push_back(4'b0010);
    @(posedge clk_sys); #1;
    req_wr = 2'b00;
    serve(1'b0, 32'h20, 1'b1, 2);
    serve(1'b1, 32'h21, 1'b1, 8);

    // second pulse while pending is ignored
    @(posedge clk_sys); #1;
    req_rd = 2'b01; req_lba0 = 32'h44;
    sb_q.push_back(4'b0001);
    @(posedge clk_sys); #1;
    req_lba0 = 32'h99;
    @(posedge clk_sys); #1;
    req_rd = 2'b00;
    serve(1'b0, 32'h44, 1'b0, 2);
    repeat (5) @(negedge clk_sys);
    check("ignored_pulse", sb_q.size(), 0);
    check("ignored_busy", req_busy, 2'b00);

    for (int v = 0; v < 7; v++) begin
      @(posedge clk_sys); #1;
      req_rd = vecs[v].rd; req_wr = vecs[v].wr;
      req_lba0 = vecs[v].lba0; req_lba1 = vecs[v].lba1;
      sb_q.push_back(vecs[v].own_a ? 4'b0010 : 4'b0001);
      if (vecs[v].n == 2) sb_q.push_back(vecs[v].own_b ? 4'b0010 : 4'b0001);
      @(posedge clk_sys); #1;
      req_rd = '0; req_wr = '0;
      serve(vecs[v].own_a, vecs[v].lba_a, vecs[v].wr_a, v % 3);
      if (vecs[v].n == 2) serve(vecs[v].own_b, vecs[v].lba_b, vecs[v].wr_b, 3);
    end

    // reset in the middle of a transfer; the stale ack must not complete it
    begin
      logic ok;
      do_reset();
      @(posedge clk_sys); #1;
      req_rd = 2'b10; req_lba1 = 32'h55;
      @(posedge clk_sys); #1;
      req_rd = 2'b00;
      wait_cmd(ok);
      @(posedge clk_sys); #1 sd_ack = 1'b1;
      @(posedge clk_sys); #1;
      @(negedge clk_sys);
      check("xfer_busy", req_busy, 2'b10);
      @(posedge clk_sys); #1 reset = 1'b1;
      @(posedge clk_sys); #1 reset = 1'b0;
      @(negedge clk_sys);
      check("mid_rst_rdwr", {sd_rd, sd_wr}, 2'b00);
      check("mid_rst_busy", req_busy, 2'b00);
      repeat (2) @(posedge clk_sys);
      #1 sd_ack = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk_sys);
        check("mid_rst_nodone", {req_err, req_done}, 4'b0000);
      end
    end

`ifdef SD_TIMEOUT_EN
    begin
      logic ok;
      do_reset();
      @(posedge clk_sys); #1;
      req_rd = 2'b01; req_lba0 = 32'h77;
      sb_q.push_back(4'b0100);
      @(posedge clk_sys); #1;
      req_rd = 2'b00;
      wait_cmd(ok);
      repeat (99) @(posedge clk_sys);
      @(negedge clk_sys);
      check("to_rd_hold", sd_rd, 1'b1);
      check("to_err_early", req_err, 2'b00);
      @(negedge clk_sys);
      check("to_rd_drop", sd_rd, 1'b0);
      check("to_err", req_err, 2'b01);
      check("to_nodone", req_done, 2'b00);
      @(negedge clk_sys);
      check("to_err_1cyc", req_err, 2'b00);
    end
`endif

    repeat (4) @(negedge clk_sys);
    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
